// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, receiver state encoding and parity helper.
package uart_pkg;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  // Bit that makes the total number of ones (data plus this bit) odd.
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and parity mode in, received byte and status out.
interface uart_rx_if;

  logic       RX_in;
  logic       enable_parity;
  logic [7:0] rx_data_8bit;
  logic       valid_out;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  // master is the receiver producing parallel bytes; slave drives the line and consumes bytes
  modport master (
    input  RX_in, enable_parity,
    output rx_data_8bit, valid_out, parity_error, framing_error, busy
  );

  modport slave (
    output RX_in, enable_parity,
    input  rx_data_8bit, valid_out, parity_error, framing_error, busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional odd parity, one stop bit, oversampled
// at CLKS_PER_BIT clocks per bit, with a one-cycle strobe and per-frame error flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.master bus
);

  import uart_pkg::*;

  localparam int             CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL = CW'(CLKS_PER_BIT - 1);

  rx_state_t            state;
  rx_state_t            state_next;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_en;
  logic                 par_err;
  logic                 stop_seen;
  logic                 stop_sample;
  logic                 tick;
  logic                 cnt_clr;
  logic [7:0]           data_q;
  logic                 valid_q;
  logic                 perr_q;
  logic                 ferr_q;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.RX_in),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RX_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    tick       = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      RX_IDLE: begin
        if (rx_s == START_BIT) begin
          state_next = RX_START;
          cnt_clr    = 1'b1;
        end
      end
      RX_START: begin
        if (cnt == HALF) begin
          tick       = 1'b1;
          cnt_clr    = 1'b1;
          state_next = (rx_s == START_BIT) ? RX_DATA : RX_IDLE;
        end
      end
      RX_DATA: begin
        if (cnt == FULL) begin
          tick    = 1'b1;
          cnt_clr = 1'b1;
          if (bit_idx == 3'(DATA_BITS - 1))
            state_next = par_en ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (cnt == FULL) begin
          tick       = 1'b1;
          cnt_clr    = 1'b1;
          state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        // The stop bit is sampled first; results are published one cycle later.
        if (stop_seen) begin
          cnt_clr    = 1'b1;
          state_next = (stop_sample == STOP_BIT) ? RX_IDLE : RX_BREAK;
        end else if (cnt == FULL) begin
          tick    = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      RX_BREAK: begin
        if (rx_s == STOP_BIT) state_next = RX_IDLE;
      end
      default: state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      par_en      <= 1'b0;
      par_err     <= 1'b0;
      stop_seen   <= 1'b0;
      stop_sample <= 1'b1;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (cnt_clr || state == RX_IDLE || state == RX_BREAK) cnt <= '0;
      else                                                  cnt <= cnt + 1'b1;
      case (state)
        RX_START: begin
          if (tick && rx_s == START_BIT) begin
            par_en  <= bus.enable_parity;
            par_err <= 1'b0;
            bit_idx <= '0;
          end
        end
        RX_DATA: begin
          if (tick) begin
            shreg[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 1'b1;
          end
        end
        RX_PARITY: begin
          if (tick) par_err <= (rx_s != odd_parity(shreg));
        end
        RX_STOP: begin
          if (stop_seen) begin
            stop_seen <= 1'b0;
            data_q    <= shreg;
            valid_q   <= 1'b1;
            perr_q    <= par_err & par_en;
            ferr_q    <= (stop_sample != STOP_BIT);
          end else if (tick) begin
            stop_seen   <= 1'b1;
            stop_sample <= rx_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rx_data_8bit  = data_q;
  assign bus.valid_out     = valid_q;
  assign bus.parity_error  = perr_q;
  assign bus.framing_error = ferr_q;
  assign bus.busy          = (state != RX_IDLE);

endmodule
